// File: rtl/bp_update_queue_if.sv
// bp_update_queue_if: branch-resolution input and predictor-update output bundle.
//   master drives: flush_bp_i, res_valid_i, res_pc_i, res_target_i, res_cf_i,
//                  res_taken_i, res_mispredict_i, upd_ready_i
//   slave drives:  upd_valid_o, upd_is_bht_o, upd_pc_o, upd_target_o, upd_taken_o,
//                  upd_mispredict_o, full_o, drop_cnt_o
interface bp_update_queue_if #(
  parameter int VLEN  = 32,
  parameter int PCLEN = 64,
  parameter int CNT_W = 16
);
  logic             flush_bp_i;
  logic             res_valid_i;
  logic [VLEN-1:0]  res_pc_i;
  logic [PCLEN-1:0] res_target_i;
  logic [2:0]       res_cf_i;
  logic             res_taken_i;
  logic             res_mispredict_i;
  logic             upd_ready_i;
  logic             upd_valid_o;
  logic             upd_is_bht_o;
  logic [VLEN-1:0]  upd_pc_o;
  logic [VLEN-1:0]  upd_target_o;
  logic             upd_taken_o;
  logic             upd_mispredict_o;
  logic             full_o;
  logic [CNT_W-1:0] drop_cnt_o;
  modport master (
    output flush_bp_i, res_valid_i, res_pc_i, res_target_i, res_cf_i, res_taken_i,
           res_mispredict_i, upd_ready_i,
    input  upd_valid_o, upd_is_bht_o, upd_pc_o, upd_target_o, upd_taken_o,
           upd_mispredict_o, full_o, drop_cnt_o
  );
  modport slave (
    input  flush_bp_i, res_valid_i, res_pc_i, res_target_i, res_cf_i, res_taken_i,
           res_mispredict_i, upd_ready_i,
    output upd_valid_o, upd_is_bht_o, upd_pc_o, upd_target_o, upd_taken_o,
           upd_mispredict_o, full_o, drop_cnt_o
  );
endinterface

// File: rtl/bp_update_queue.sv
// bp_update_queue: buffers resolved Branch/JumpR outcomes and drains them in order
// to the BHT/BTB update port.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active low
//   bus    : bp_update_queue_if.slave (res_* in, upd_ready_i in, upd_*/full_o/drop_cnt_o out)
//   cf encoding on res_cf_i: 0 NoCF, 1 Branch, 2 Jump, 3 JumpR, 4 Return
module bp_update_queue #(
  parameter int VLEN          = 32,
  parameter int PCLEN         = 64,
  parameter bit CHERI_PRESENT = 1'b1,
  parameter int DEPTH         = 4,
  parameter int CNT_W         = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  bp_update_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] CF_BRANCH = 3'd1;
  localparam logic [2:0] CF_JUMPR  = 3'd3;
  typedef struct packed {
    logic            is_bht;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] tgt;
    logic            taken;
    logic            mis;
  } ent_t;
  ent_t             mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [VLEN-1:0]  tgt_raw;
  logic             cand, deq, enq, full, unused_tgt;
  ent_t             new_ent, head;
  // Capability targets carry the address in the low VLEN bits (the cursor).
  assign tgt_raw    = CHERI_PRESENT ? bus.res_target_i[VLEN-1:0] : VLEN'(bus.res_target_i);
  assign unused_tgt = ^(bus.res_target_i >> VLEN);
  assign full       = cnt_q == CW'(DEPTH);
  assign head       = mem_q[rd_q];
  always_comb begin
    cand    = bus.res_valid_i & (bus.res_cf_i == CF_BRANCH | bus.res_cf_i == CF_JUMPR);
    deq     = (cnt_q != '0) & bus.upd_ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    enq     = cand & ~bus.flush_bp_i & (~full | deq);
    new_ent = '{is_bht: bus.res_cf_i == CF_BRANCH, pc: bus.res_pc_i,
                tgt: tgt_raw & ~VLEN'(1), taken: bus.res_taken_i, mis: bus.res_mispredict_i};
    cnt_d   = bus.flush_bp_i ? '0 : cnt_q + CW'(enq) - CW'(deq);
    rd_d    = bus.flush_bp_i ? '0 : rd_q + PW'(deq);
    wr_d    = bus.flush_bp_i ? '0 : wr_q + PW'(enq);
    drop_d  = (cand & ~bus.flush_bp_i & full & ~deq & (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (enq) mem_q[wr_q] <= new_ent;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end
  assign bus.upd_valid_o      = cnt_q != '0;
  assign bus.upd_is_bht_o     = head.is_bht;
  assign bus.upd_pc_o         = head.pc;
  assign bus.upd_target_o     = head.tgt;
  assign bus.upd_taken_o      = head.taken;
  assign bus.upd_mispredict_o = head.mis;
  assign bus.full_o           = full;
  assign bus.drop_cnt_o       = drop_q;
endmodule
